part_dpram_clr: RTL and testbench
=================================

Name: part_dpram_clr

Overview:
Parametrised single-clock true dual-port synchronous SRAM with a built-in clear sequencer. It is the general successor to the fixed 1kx24 VMEM1 part, for VMEM0/VMEM1, the PDL maps and other map/scratch RAMs. It adds configurable geometry, read latency and same-port write mode. It also adds defined cross-port collision rules and a hardware sweep that fills every word with INIT_VALUE after reset or on request.

Parameters:
ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
DATA_WIDTH, 24, word width in bits
READ_LATENCY, 1, clocks from rden to q valid; legal values 1 or 2
WRITE_MODE_A, 0, port A read-during-write: 0=read_first, 1=write_first, 2=no_change
WRITE_MODE_B, 0, same as WRITE_MODE_A, for port B
INIT_VALUE, 0, DATA_WIDTH-bit value written by the clear sweep

Ports:
clk  in  1  single clock for both ports
reset  in  1  synchronous, active-high; starts a clear sweep
clear  in  1  one-cycle request for a new clear sweep when idle
busy  out  1  high while the clear sweep runs
address_a  in  ADDR_WIDTH  port A address
data_a  in  DATA_WIDTH  port A write data
wren_a  in  1  port A write enable
rden_a  in  1  port A read enable
q_a  out  DATA_WIDTH  port A read data
address_b  in  ADDR_WIDTH  port B address
data_b  in  DATA_WIDTH  port B write data
wren_b  in  1  port B write enable
rden_b  in  1  port B read enable
q_b  out  DATA_WIDTH  port B read data
collision  out  1  registered pulse: both ports wrote the same address

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high. While reset=1, q_a, q_b, pipeline registers and collision are 0, busy=1, and the sweep counter is 0.
- FSM states: IDLE and CLEAR.
  - reset forces CLEAR with counter 0.
  - IDLE -> CLEAR when clear=1 (counter set to 0, busy=1 next cycle). clear is ignored while in CLEAR.
  - In CLEAR: one word per cycle, mem[counter] <= INIT_VALUE, counter increments.
  - On the cycle that writes address 2**ADDR_WIDTH-1, the next state is IDLE. busy drops the following cycle.
  - A sweep therefore takes exactly 2**ADDR_WIDTH cycles after reset deasserts.
- While busy=1: wren_a and wren_b are dropped, rden_a and rden_b are ignored, q_a and q_b hold their values, and collision stays 0.
- Reads:
  - rden_x=1 on edge N: the addressed word appears on q_x after edge N+READ_LATENCY-1. Latency 1 means visible after edge N; latency 2 means after edge N+1.
  - rden_x=0: the output stage holds. With latency 2 the pipeline advances only with enable, so q always shows the last read word.
- Same-port read-during-write (rden_x and wren_x both set):
  - read_first: q gets the old word.
  - write_first: q gets data_x.
  - no_change: q holds its previous value.
  - A write with rden_x=0 never changes q_x.
- Cross-port read/write to the same address in the same cycle: the reader always gets the old word (read_first), whatever the write mode.
- Write/write collision (wren_a & wren_b, address_a == address_b): port A wins, port B's write is dropped, and collision=1 on the next cycle for one cycle. Different-address dual writes both commit.
- Reset mid-sweep: the sweep restarts from address 0. Reset mid-read flushes the latency-2 pipeline to 0.
- No asynchronous paths. All outputs are registered except busy, which is decoded from the state register.

Test Plan:
1. Sweep, ADDR_WIDTH=4, INIT_VALUE=24'h5A5A5A: pulse reset for 1 cycle -> busy=1 for exactly 16 cycles. Then a read of every address returns 5A5A5A.
2. Latency 1 vs 2: write 24'o1234567 to address 7 via A, then read via B with rden_b for 1 cycle. LAT=1 -> q_b=1234567 after the same edge; LAT=2 -> after the next edge. Then deassert rden_b and change address -> q_b holds.
3. Write modes: mem[3]=11; A writes 22 to address 3 with rden_a=1. read_first -> q_a=11; write_first -> q_a=22; no_change -> q_a keeps its prior value. A following read gives 22 in all modes.
4. Collision: A writes 0AAAAA and B writes 0BBBBB to address 9 in the same cycle -> mem[9]=0AAAAA and collision pulses high for 1 cycle. Repeat with addresses 9 and 10 -> both written, collision stays 0.
5. Cross-port read: mem[5]=1; A writes 2 to address 5 while B reads address 5 -> q_b=1, and the next B read returns 2.
6. Busy gating and reset mid-sweep: assert clear, then issue writes during busy -> after the sweep all words equal INIT_VALUE. Assert reset at counter=8 -> busy lasts a full 2**ADDR_WIDTH cycles after reset deasserts.

Source files
------------

// File: rtl/part_dpram_clr.sv
// part_dpram_clr
// Single-clock true dual-port synchronous RAM with a built-in clear sweep.
// After reset, or on a clear request while idle, every word is filled with
// INIT_VALUE at one word per cycle. During the sweep both user ports are gated off.
//
// Ports:
//   clk                  single clock for both ports
//   reset                synchronous, active-high; restarts the clear sweep
//   clear                one-cycle request for a new sweep (honoured only when idle)
//   busy                 high while the sweep runs (decoded from the state register)
//   address_a/b          port addresses
//   data_a/b             port write data
//   wren_a/b             port write enables
//   rden_a/b             port read enables
//   q_a/q_b              registered read data (READ_LATENCY 1 or 2)
//   collision            one-cycle pulse after both ports wrote the same address
module part_dpram_clr #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 24,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE_A = 0,
    parameter int WRITE_MODE_B = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    input  logic                  rden_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    input  logic                  rden_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  collision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   count, count_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    same_addr;
    logic                    wr_a, wr_b;
    logic                    rd_a, rd_b;
    logic [DATA_WIDTH-1:0]   rd_data_a, rd_data_b;

    assign busy = (state == CLEAR);

    // Sweep sequencer: the last word written is the all-ones address, after
    // which the machine returns to IDLE on the following edge.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            CLEAR: begin
                count_next = count + 1'b1;
                if (&count) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Port qualification. Port A wins a same-address write; a no_change
    // read-during-write is treated as no read so the output stage holds.
    // The memory is read combinationally before the edge, so any read
    // (including a cross-port read of an address being written) sees the old word.
    always_comb begin
        same_addr = (address_a == address_b);
        wr_a      = wren_a && !busy;
        wr_b      = wren_b && !busy && !(wren_a && same_addr);
        rd_a      = rden_a && !busy && !((WRITE_MODE_A == 2) && wren_a);
        rd_b      = rden_b && !busy && !((WRITE_MODE_B == 2) && wren_b);
        rd_data_a = ((WRITE_MODE_A == 1) && wren_a) ? data_a : mem[address_a];
        rd_data_b = ((WRITE_MODE_B == 1) && wren_b) ? data_b : mem[address_b];
    end

    // Storage array: the sweep owns the write path while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[count] <= INIT_VALUE;
            end else begin
                if (wr_a) begin
                    mem[address_a] <= data_a;
                end
                if (wr_b) begin
                    mem[address_b] <= data_b;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            collision <= 1'b0;
        end else begin
            collision <= wren_a && wren_b && same_addr && !busy;
        end
    end

    // Output stage. With two-cycle latency a valid bit travels with the data
    // so the output register only loads words that were actually read.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] pipe_a, pipe_b;
        logic                  pipe_va, pipe_vb;

        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_a  <= '0;
                pipe_b  <= '0;
                pipe_va <= 1'b0;
                pipe_vb <= 1'b0;
                q_a     <= '0;
                q_b     <= '0;
            end else if (busy) begin
                pipe_va <= 1'b0;
                pipe_vb <= 1'b0;
            end else begin
                pipe_va <= rd_a;
                pipe_vb <= rd_b;
                if (rd_a) begin
                    pipe_a <= rd_data_a;
                end
                if (rd_b) begin
                    pipe_b <= rd_data_b;
                end
                if (pipe_va) begin
                    q_a <= pipe_a;
                end
                if (pipe_vb) begin
                    q_b <= pipe_b;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                q_a <= '0;
                q_b <= '0;
            end else begin
                if (rd_a) begin
                    q_a <= rd_data_a;
                end
                if (rd_b) begin
                    q_b <= rd_data_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_part_dpram_clr.sv
// tb_part_dpram_clr
// Drives three RAM instances with identical stimulus:
//   inst 0: latency 1, read_first   inst 1: latency 2, write_first
//   inst 2: latency 1, no_change
// A behavioural model of the memory contents, sweep length and read delivery
// is checked against every instance each cycle; literal checks pin key values.
module tb_part_dpram_clr;

    localparam logic [23:0] INIT = 24'h5A5A5A;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [3:0]  address_a, address_b;
    logic [23:0] data_a, data_b;
    logic        wren_a, rden_a, wren_b, rden_b;

    logic [2:0][23:0] qa, qb;
    logic [2:0]       bz, co;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    part_dpram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(24), .READ_LATENCY(1),
                     .WRITE_MODE_A(0), .WRITE_MODE_B(0), .INIT_VALUE(INIT)) u_rf (
        .clk(clk), .reset(reset), .clear(clear), .busy(bz[0]),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(qa[0]),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b), .q_b(qb[0]),
        .collision(co[0]));

    part_dpram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(24), .READ_LATENCY(2),
                     .WRITE_MODE_A(1), .WRITE_MODE_B(1), .INIT_VALUE(INIT)) u_wf (
        .clk(clk), .reset(reset), .clear(clear), .busy(bz[1]),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(qa[1]),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b), .q_b(qb[1]),
        .collision(co[1]));

    part_dpram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(24), .READ_LATENCY(1),
                     .WRITE_MODE_A(2), .WRITE_MODE_B(2), .INIT_VALUE(INIT)) u_nc (
        .clk(clk), .reset(reset), .clear(clear), .busy(bz[2]),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(qa[2]),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b), .q_b(qb[2]),
        .collision(co[2]));

    // Behavioural model state, one copy per instance.
    logic [23:0] mm [3][16];
    logic [23:0] mqa [3], mqb [3], mpa [3], mpb [3];
    logic        mpva [3], mpvb [3], mcoll [3];
    int          busy_left [3];
    bit          model_valid = 1'b0;

    // Model update: all reads see the array before this edge's writes; port A
    // wins a shared-address write; the sweep fills one word per cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic        fa, fb, cl;
            logic [23:0] va, vb;
            if (reset) begin
                busy_left[i] = 16;
                mqa[i] = '0; mqb[i] = '0; mpa[i] = '0; mpb[i] = '0;
                mpva[i] = 1'b0; mpvb[i] = 1'b0; mcoll[i] = 1'b0;
                model_valid = 1'b1;
            end else if (busy_left[i] > 0) begin
                mm[i][16 - busy_left[i]] = INIT;
                busy_left[i] = busy_left[i] - 1;
                mcoll[i] = 1'b0;
                mpva[i] = 1'b0; mpvb[i] = 1'b0;
            end else begin
                fa = rden_a && !(i == 2 && wren_a);
                fb = rden_b && !(i == 2 && wren_b);
                va = (i == 1 && wren_a) ? data_a : mm[i][address_a];
                vb = (i == 1 && wren_b) ? data_b : mm[i][address_b];
                cl = wren_a && wren_b && (address_a == address_b);
                if (wren_b) mm[i][address_b] = data_b;
                if (wren_a) mm[i][address_a] = data_a;
                mcoll[i] = cl;
                if (i == 1) begin
                    if (mpva[i]) mqa[i] = mpa[i];
                    if (mpvb[i]) mqb[i] = mpb[i];
                    mpva[i] = fa; mpvb[i] = fb;
                    if (fa) mpa[i] = va;
                    if (fb) mpb[i] = vb;
                end else begin
                    if (fa) mqa[i] = va;
                    if (fb) mqb[i] = vb;
                end
                if (clear) busy_left[i] = 16;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                tests += 4;
                if (qa[i] !== mqa[i]) begin
                    fails++;
                    $display("[TB] FAIL model_q_a[%0d] t=%0t got %h want %h", i, $time, qa[i], mqa[i]);
                end
                if (qb[i] !== mqb[i]) begin
                    fails++;
                    $display("[TB] FAIL model_q_b[%0d] t=%0t got %h want %h", i, $time, qb[i], mqb[i]);
                end
                if (bz[i] !== (busy_left[i] > 0)) begin
                    fails++;
                    $display("[TB] FAIL model_busy[%0d] t=%0t got %b want %b", i, $time, bz[i], busy_left[i] > 0);
                end
                if (co[i] !== mcoll[i]) begin
                    fails++;
                    $display("[TB] FAIL model_collision[%0d] t=%0t got %b want %b", i, $time, co[i], mcoll[i]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of port activity from a negedge, then drop the enables.
    task automatic applyStimulus(input logic wa, input logic [3:0] aa, input logic [23:0] da, input logic ra,
                                 input logic wb, input logic [3:0] ab, input logic [23:0] db, input logic rb);
        wren_a = wa; address_a = aa; data_a = da; rden_a = ra;
        wren_b = wb; address_b = ab; data_b = db; rden_b = rb;
        @(negedge clk);
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 4'd0, 24'd0, 1'b0);
    endtask

    // Pulse reset for one cycle and count the cycles busy stays high afterwards.
    task automatic resetAndCount(input string name);
        int n;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && bz[0] === 1'b1; i++) begin
            n++;
            @(negedge clk);
        end
        checkOutput(name, 24'(n), 24'd16);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Sweep after reset, then every word reads back INIT.
        resetAndCount("sweep_len");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 4'(k), 24'd0, 1'b1, 1'b0, 4'(15 - k), 24'd0, 1'b1);
            checkOutput("sweep_rd", qa[0], 24'h5A5A5A);
        end
        idleCycle();

        // Read latency and output hold.
        applyStimulus(1'b1, 4'd7, 24'o1234567, 1'b0, 1'b0, 4'd0, 24'd0, 1'b0);
        applyStimulus(1'b0, 4'd7, 24'd0, 1'b0, 1'b0, 4'd7, 24'd0, 1'b1);
        checkOutput("lat1_q_b", qb[0], 24'o1234567);
        checkOutput("lat2_early", qb[1], 24'h5A5A5A);
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 4'd3, 24'd0, 1'b0);
        checkOutput("lat2_q_b", qb[1], 24'o1234567);
        checkOutput("lat1_hold", qb[0], 24'o1234567);
        idleCycle();
        checkOutput("lat2_hold", qb[1], 24'o1234567);

        // Same-port read-during-write in each mode.
        applyStimulus(1'b1, 4'd3, 24'h000011, 1'b0, 1'b0, 4'd0, 24'd0, 1'b0);
        applyStimulus(1'b1, 4'd3, 24'h000022, 1'b1, 1'b0, 4'd0, 24'd0, 1'b0);
        checkOutput("rdw_read_first", qa[0], 24'h000011);
        checkOutput("rdw_no_change", qa[2], 24'h5A5A5A);
        idleCycle();
        checkOutput("rdw_write_first", qa[1], 24'h000022);
        applyStimulus(1'b0, 4'd3, 24'd0, 1'b1, 1'b0, 4'd0, 24'd0, 1'b0);
        checkOutput("rdw_after_rf", qa[0], 24'h000022);
        checkOutput("rdw_after_nc", qa[2], 24'h000022);
        idleCycle();
        checkOutput("rdw_after_wf", qa[1], 24'h000022);

        // Write/write collision and different-address dual write.
        applyStimulus(1'b1, 4'd9, 24'h0AAAAA, 1'b0, 1'b1, 4'd9, 24'h0BBBBB, 1'b0);
        checkOutput("coll_pulse", 24'(co[0]), 24'd1);
        idleCycle();
        checkOutput("coll_one_cycle", 24'(co[0]), 24'd0);
        applyStimulus(1'b0, 4'd9, 24'd0, 1'b1, 1'b0, 4'd9, 24'd0, 1'b1);
        checkOutput("coll_winner_a", qa[0], 24'h0AAAAA);
        checkOutput("coll_winner_b", qb[0], 24'h0AAAAA);
        applyStimulus(1'b1, 4'd9, 24'h0CCCCC, 1'b0, 1'b1, 4'd10, 24'h0DDDDD, 1'b0);
        checkOutput("diff_addr_no_coll", 24'(co[0]), 24'd0);
        applyStimulus(1'b0, 4'd9, 24'd0, 1'b1, 1'b0, 4'd10, 24'd0, 1'b1);
        checkOutput("dual_wr_a", qa[0], 24'h0CCCCC);
        checkOutput("dual_wr_b", qb[0], 24'h0DDDDD);

        // Cross-port read of an address being written returns the old word.
        applyStimulus(1'b1, 4'd5, 24'h000001, 1'b0, 1'b0, 4'd0, 24'd0, 1'b0);
        applyStimulus(1'b1, 4'd5, 24'h000002, 1'b0, 1'b0, 4'd5, 24'd0, 1'b1);
        checkOutput("xport_old_rf", qb[0], 24'h000001);
        checkOutput("xport_old_nc", qb[2], 24'h000001);
        idleCycle();
        checkOutput("xport_old_wf", qb[1], 24'h000001);
        applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 4'd5, 24'd0, 1'b1);
        checkOutput("xport_new", qb[0], 24'h000002);

        // Clear request; writes, reads and further clears during busy are ignored.
        clear = 1'b1;
        idleCycle();
        clear = 1'b0;
        checkOutput("clear_busy", 24'(bz[0]), 24'd1);
        for (int k = 0; k < 4; k++) begin
            clear = 1'b1;
            applyStimulus(1'b1, 4'(k), 24'hFFFFFF, 1'b1, 1'b1, 4'(k + 4), 24'h123456, 1'b1);
        end
        clear = 1'b0;
        for (int i = 0; i < 40 && bz[0] === 1'b1; i++) begin
            @(negedge clk);
        end
        checkOutput("clear_done", 24'(bz[0]), 24'd0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 4'(k), 24'd0, 1'b1, 1'b0, 4'd0, 24'd0, 1'b0);
            checkOutput("clear_rd", qa[0], 24'h5A5A5A);
        end

        // Reset in the middle of a sweep restarts it from address 0.
        clear = 1'b1;
        idleCycle();
        clear = 1'b0;
        repeat (8) idleCycle();
        resetAndCount("reset_mid_len");
        idleCycle();
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
